// File: rtl/inv_mix_col_iter_if.sv
// Handshake bundle for inv_mix_col_iter: state-in and state-out valid/ready channels.
// Revision: 1.0
`default_nettype none

interface inv_mix_col_iter_if;
   logic [127:0] in_data;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] out_data;
   logic         out_valid;
   logic         out_ready;

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid
   );

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid
   );
endinterface

`default_nettype wire

// File: rtl/inv_mix_col_iter.sv
// inv_mix_col_iter: iterative AES InvMixColumns, one column per cycle.
// Optional forward MixColumns mode via INV_MIX_COL_FWD_EN. Revision: 1.0
`default_nettype none

module inv_mix_col_iter #(
   parameter int NUM_COLS = 4,
   parameter int COL_W    = 32
) (
   input  wire logic           clk,
   input  wire logic           rst_n,
`ifdef INV_MIX_COL_FWD_EN
   input  wire logic           fwd_mode,
`endif
   inv_mix_col_iter_if.slave   bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_next_state;
   logic [1:0]         r_col_cnt;
   logic [127:0]       r_data;
   logic [COL_W-1:0]   w_col;
   logic [COL_W-1:0]   w_col_res;
   logic [127:0]       w_next_data;
   logic               w_accept;
   logic               w_in_ready;
   logic               w_out_valid;
`ifdef INV_MIX_COL_FWD_EN
   logic               r_fwd;
`endif

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // Build 09/0b/0d/0e from the shared x2/x4/x8 chain of a single byte.
   function automatic logic [31:0] inv_mult(input logic [7:0] a);
      logic [7:0] x2, x4, x8;
      x2 = xtime(a);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return {x8 ^ x4 ^ x2, x8 ^ x2 ^ a, x8 ^ x4 ^ a, x8 ^ a};  // {0e,0b,0d,09}
   endfunction

   function automatic logic [31:0] inv_mix(input logic [31:0] c);
      logic [31:0] m0, m1, m2, m3;
      m0 = inv_mult(c[31:24]);
      m1 = inv_mult(c[23:16]);
      m2 = inv_mult(c[15:8]);
      m3 = inv_mult(c[7:0]);
      return {m0[31:24] ^ m1[23:16] ^ m2[15:8]  ^ m3[7:0],
              m0[7:0]   ^ m1[31:24] ^ m2[23:16] ^ m3[15:8],
              m0[15:8]  ^ m1[7:0]   ^ m2[31:24] ^ m3[23:16],
              m0[23:16] ^ m1[15:8]  ^ m2[7:0]   ^ m3[31:24]};
   endfunction

`ifdef INV_MIX_COL_FWD_EN
   function automatic logic [31:0] fwd_mix(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      a0 = c[31:24];
      a1 = c[23:16];
      a2 = c[15:8];
      a3 = c[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction
`endif

   always_comb begin
      w_col = r_data[127:96];
      case (r_col_cnt)
         2'd0: w_col = r_data[127:96];
         2'd1: w_col = r_data[95:64];
         2'd2: w_col = r_data[63:32];
         2'd3: w_col = r_data[31:0];
      endcase
`ifdef INV_MIX_COL_FWD_EN
      w_col_res = r_fwd ? fwd_mix(w_col) : inv_mix(w_col);
`else
      w_col_res = inv_mix(w_col);
`endif
      w_next_data = r_data;
      case (r_col_cnt)
         2'd0: w_next_data[127:96] = w_col_res;
         2'd1: w_next_data[95:64]  = w_col_res;
         2'd2: w_next_data[63:32]  = w_col_res;
         2'd3: w_next_data[31:0]   = w_col_res;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_in_ready   = 1'b0;
      w_out_valid  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_in_ready = 1'b1;
            if (bus.in_valid) begin
               w_next_state = S_BUSY;
            end
         end
         S_BUSY: begin
            if (r_col_cnt == 2'(NUM_COLS - 1)) begin
               w_next_state = S_DONE;
            end
         end
         S_DONE: begin
            w_out_valid = 1'b1;
            if (bus.out_ready) begin
               w_next_state = S_IDLE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   assign w_accept = w_in_ready & bus.in_valid;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_col_cnt <= 2'd0;
         r_data    <= 128'd0;
`ifdef INV_MIX_COL_FWD_EN
         r_fwd     <= 1'b0;
`endif
      end else if (w_accept) begin
         r_col_cnt <= 2'd0;
         r_data    <= bus.in_data;
`ifdef INV_MIX_COL_FWD_EN
         r_fwd     <= fwd_mode;
`endif
      end else if (r_state == S_BUSY) begin
         // Natural 2-bit wrap brings the counter back to 0 on entry to DONE.
         r_col_cnt <= r_col_cnt + 2'd1;
         r_data    <= w_next_data;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.out_data  = r_data;

endmodule

`default_nettype wire

// File: tb/tb_inv_mix_col_iter.sv
// Testbench for inv_mix_col_iter: directed vectors with a queued reference model.
// Revision: 1.0
`default_nettype none

module tb_inv_mix_col_iter;

   logic clk;
   logic rst_n;
   logic fwd;
   int   n_chk;
   int   n_fail;
   logic [127:0] exp_q[$];
   logic [127:0] held;
   int   lat;

   inv_mix_col_iter_if bif ();

   inv_mix_col_iter dut (
      .clk      (clk),
      .rst_n    (rst_n),
`ifdef INV_MIX_COL_FWD_EN
      .fwd_mode (fwd),
`endif
      .bus      (bif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [127:0] model(input logic [127:0] s, input logic f);
      logic [7:0] ci [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      logic [7:0] cf [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
      logic [127:0] r;
      logic [7:0] a [4];
      logic [7:0] b;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int k = 0; k < 4; k++) a[k] = s[127 - 32*c - 8*k -: 8];
         for (int row = 0; row < 4; row++) begin
            b = 8'h00;
            for (int k = 0; k < 4; k++)
               b = b ^ gmul(a[k], f ? cf[(k - row + 4) % 4] : ci[(k - row + 4) % 4]);
            r[127 - 32*c - 8*row -: 8] = b;
         end
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Offer a state at the next falling edge and hold it until accepted.
   task automatic send(input logic [127:0] d, input logic f);
      int guard;
      @(negedge clk);
      bif.in_data  = d;
      bif.in_valid = 1'b1;
      fwd          = f;
      guard        = 0;
      while (!bif.in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      chk("accept_ready", {127'd0, bif.in_ready}, 128'd1);
      @(posedge clk);
      exp_q.push_back(model(d, f));
      @(negedge clk);
      bif.in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int l);
      l = 0;
      while (!bif.out_valid && l < 20) begin
         @(negedge clk);
         l++;
      end
      chk("out_valid_seen", {127'd0, bif.out_valid}, 128'd1);
   endtask

   task automatic take(input string tag);
      logic [127:0] e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      chk(tag, bif.out_data, e);
      bif.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run(input string tag, input logic [127:0] d, input logic f);
      send(d, f);
      wait_valid(lat);
      take(tag);
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      rst_n = 1'b0;
      fwd = 1'b0;
      bif.in_data = '0;
      bif.in_valid = 1'b0;
      bif.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      chk("rst_out_data", bif.out_data, 128'd0);
      chk("rst_out_valid", {127'd0, bif.out_valid}, 128'd0);
      chk("rst_in_ready", {127'd0, bif.in_ready}, 128'd1);

      // Known vector: latency, value and single-cycle valid.
      send(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b0);
      chk("vec1_model", exp_q[0], 128'hdb135345_f20a225c_01010101_c6c6c6c6);
      wait_valid(lat);
      chk("vec1_latency", 128'(lat), 128'd4);
      take("vec1_data");
      chk("vec1_valid_drop", {127'd0, bif.out_valid}, 128'd0);
      chk("vec1_idle_ready", {127'd0, bif.in_ready}, 128'd1);

      send(128'h046681e5_e0cb199a_48f8d37a_2806264c, 1'b0);
      chk("fips_model", exp_q[0], 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5);
      wait_valid(lat);
      take("fips_data");

      // Back-pressure with a second state offered during the stall.
      bif.out_ready = 1'b0;
      send(128'h046681e5_e0cb199a_48f8d37a_2806264c, 1'b0);
      wait_valid(lat);
      held = bif.out_data;
      bif.in_data  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
      bif.in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_valid", {127'd0, bif.out_valid}, 128'd1);
         chk("bp_in_ready", {127'd0, bif.in_ready}, 128'd0);
         chk("bp_stable", bif.out_data, held);
      end
      take("bp_data");
      chk("bp_release_ready", {127'd0, bif.in_ready}, 128'd1);
      @(posedge clk);
      exp_q.push_back(model(bif.in_data, 1'b0));
      @(negedge clk);
      bif.in_valid = 1'b0;
      wait_valid(lat);
      chk("bp_second_latency", 128'(lat), 128'd4);
      take("bp_second_data");

      // Reset on the second BUSY cycle discards the partial state.
      send(128'h046681e5_e0cb199a_48f8d37a_2806264c, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      void'(exp_q.pop_back());
      chk("mrst_out_data", bif.out_data, 128'd0);
      chk("mrst_out_valid", {127'd0, bif.out_valid}, 128'd0);
      chk("mrst_in_ready", {127'd0, bif.in_ready}, 128'd1);
      run("mrst_fresh", 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b0);

      run("zero", 128'd0, 1'b0);
      chk("zero_model", model(128'd0, 1'b0), 128'd0);
      send({4{32'hd5d5d7d6}}, 1'b0);
      chk("d5_model", exp_q[0], {4{32'hd4d4d4d5}});
      wait_valid(lat);
      take("d5_data");
      send({4{32'h4d7ebdf8}}, 1'b0);
      chk("4d_model", exp_q[0], {4{32'h2d26314c}});
      wait_valid(lat);
      take("4d_data");

`ifdef INV_MIX_COL_FWD_EN
      send(128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b1);
      chk("fwd_model", exp_q[0], 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
      wait_valid(lat);
      chk("fwd_latency", 128'(lat), 128'd4);
      take("fwd_data");
      run("rt_fwd", 128'h046681e5_e0cb199a_48f8d37a_2806264c, 1'b1);
      send(model(128'h046681e5_e0cb199a_48f8d37a_2806264c, 1'b1), 1'b0);
      chk("rt_model", exp_q[0], 128'h046681e5_e0cb199a_48f8d37a_2806264c);
      wait_valid(lat);
      take("rt_inv");
`endif

      chk("queue_empty", 128'(exp_q.size()), 128'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $fatal(1, "FAIL watchdog timeout");
   end

endmodule

`default_nettype wire
